// File: rtl/sio_target_regbank.sv
// Command responder behind sio_target: decodes 80-bit command words and executes them
// on a 32-bit read/write register bank plus a read-only status window.
module sio_target_regbank #(
  parameter int          NREGS   = 8,
  parameter int          NSTAT   = 4,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic                  c,
  input  logic                  r,
  input  logic [79:0]           wdata,
  input  logic                  wvalid,
  output logic [31:0]           rdata,
  output logic [32*NREGS-1:0]   regs,
  output logic [NREGS-1:0]      wstrobe,
  input  logic [32*NSTAT-1:0]   stat,
  output logic [15:0]           err_count
);

  localparam logic [7:0] OP_WRITE      = 8'h01;
  localparam logic [7:0] OP_READ       = 8'h02;
  localparam logic [7:0] OP_SET        = 8'h03;
  localparam logic [7:0] OP_CLR        = 8'h04;
  localparam logic [7:0] OP_WRITE_READ = 8'h05;

  logic [7:0]         op_s;
  logic [7:0]         addr_s;
  logic [31:0]        data_s;
  logic               unused_s;

  logic               reg_hit_s;
  logic               stat_hit_s;
  logic [31:0]        cur_s;
  logic [31:0]        stat_val_s;
  logic [31:0]        new_val_s;
  logic               wr_s;
  logic               err_inc_s;

  logic [32*NREGS-1:0] regs_nxt_s;
  logic [NREGS-1:0]    wstrobe_nxt_s;
  logic [31:0]         rdata_nxt_s;
  logic [15:0]         err_nxt_s;

  logic [32*NREGS-1:0] regs_r;
  logic [NREGS-1:0]    wstrobe_r;
  logic [31:0]         rdata_r;
  logic [15:0]         err_r;

  assign op_s     = wdata[79:72];
  assign addr_s   = wdata[39:32];
  assign data_s   = wdata[31:0];
  assign unused_s = ^wdata[71:40];

  // Address decode: selected register value and selected status word, OR-reduced per match.
  always_comb begin
    reg_hit_s  = 1'b0;
    stat_hit_s = 1'b0;
    cur_s      = 32'h0000_0000;
    stat_val_s = 32'h0000_0000;
    for (int k = 0; k < NREGS; k++) begin
      reg_hit_s = reg_hit_s | (addr_s == 8'(k));
      cur_s     = cur_s | ((addr_s == 8'(k)) ? regs_r[32*k +: 32] : 32'h0000_0000);
    end
    for (int i = 0; i < NSTAT; i++) begin
      stat_hit_s = stat_hit_s | (addr_s == 8'(64 + i));
      stat_val_s = stat_val_s | ((addr_s == 8'(64 + i)) ? stat[32*i +: 32] : 32'h0000_0000);
    end
  end

  // Command execution: next register, strobe, read-back and error-count values.
  always_comb begin
    regs_nxt_s    = regs_r;
    wstrobe_nxt_s = '0;
    rdata_nxt_s   = rdata_r;
    new_val_s     = cur_s;
    wr_s          = 1'b0;
    err_inc_s     = 1'b0;
    if (wvalid) begin
      case (op_s)
        OP_WRITE, OP_WRITE_READ: begin
          new_val_s = data_s;
          wr_s      = 1'b1;
        end
        OP_SET: begin
          new_val_s = cur_s | data_s;
          wr_s      = 1'b1;
        end
        OP_CLR: begin
          new_val_s = cur_s & ~data_s;
          wr_s      = 1'b1;
        end
        OP_READ: begin
          if (reg_hit_s) begin
            rdata_nxt_s = cur_s;
          end else if (stat_hit_s) begin
            rdata_nxt_s = stat_val_s;
          end else begin
            err_inc_s = 1'b1;
          end
        end
        default: begin
          err_inc_s = 1'b1;
        end
      endcase
      // Write-class ops always read back the resulting value; status/unmapped targets are errors.
      if (wr_s && reg_hit_s) begin
        rdata_nxt_s = new_val_s;
        for (int k = 0; k < NREGS; k++) begin
          wstrobe_nxt_s[k]       = (addr_s == 8'(k));
          regs_nxt_s[32*k +: 32] = (addr_s == 8'(k)) ? new_val_s : regs_r[32*k +: 32];
        end
      end else if (wr_s) begin
        err_inc_s = 1'b1;
      end else begin
        wstrobe_nxt_s = '0;
      end
    end else begin
      err_inc_s = 1'b0;
    end
    err_nxt_s = (err_inc_s && (err_r != 16'hFFFF)) ? err_r + 16'd1 : err_r;
  end

  // State registers; a command coinciding with reset is dropped.
  always_ff @(posedge c) begin
    if (r) begin
      regs_r    <= {NREGS{RST_VAL}};
      wstrobe_r <= '0;
      rdata_r   <= 32'h0000_0000;
      err_r     <= 16'h0000;
    end else begin
      regs_r    <= regs_nxt_s;
      wstrobe_r <= wstrobe_nxt_s;
      rdata_r   <= rdata_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  assign regs      = regs_r;
  assign wstrobe   = wstrobe_r;
  assign rdata     = rdata_r;
  assign err_count = err_r;

endmodule

// File: tb/tb_sio_target_regbank.sv
// Self-checking bench for sio_target_regbank: directed vector table, reset/saturation
// sequences and random commands checked against an array-based reference model.
module tb_sio_target_regbank;

  localparam int NREGS = 8;
  localparam int NSTAT = 4;

  logic                c = 1'b0;
  logic                r;
  logic [79:0]         wdata;
  logic                wvalid;
  logic [31:0]         rdata;
  logic [32*NREGS-1:0] regs;
  logic [NREGS-1:0]    wstrobe;
  logic [32*NSTAT-1:0] stat;
  logic [15:0]         err_count;

  sio_target_regbank #(.NREGS(NREGS), .NSTAT(NSTAT), .RST_VAL(32'h0000_0000)) dut (
    .c(c), .r(r), .wdata(wdata), .wvalid(wvalid), .rdata(rdata), .regs(regs),
    .wstrobe(wstrobe), .stat(stat), .err_count(err_count)
  );

  always #5 c = ~c;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0]      m_regs [NREGS];
  logic [31:0]      m_rdata;
  logic [15:0]      m_err;
  logic [NREGS-1:0] m_wstrobe;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic [15:0] exp_err;
    logic [7:0]  exp_wstrobe;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) m_regs[k] = 32'h0000_0000;
    m_rdata   = 32'h0000_0000;
    m_err     = 16'h0000;
    m_wstrobe = '0;
  endtask

  task automatic model_error();
    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  // Applies one command's effect according to the op/address rules.
  task automatic model_apply(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] data);
    int a;
    a = int'(addr);
    m_wstrobe = '0;
    if (op == 8'h01 || op == 8'h03 || op == 8'h04 || op == 8'h05) begin
      if (a < NREGS) begin
        if (op == 8'h03)      m_regs[a] = m_regs[a] | data;
        else if (op == 8'h04) m_regs[a] = m_regs[a] & ~data;
        else                  m_regs[a] = data;
        m_rdata      = m_regs[a];
        m_wstrobe[a] = 1'b1;
      end else begin
        model_error();
      end
    end else if (op == 8'h02) begin
      if (a < NREGS) m_rdata = m_regs[a];
      else if (a >= 64 && a < 64 + NSTAT) m_rdata = stat[32*(a-64) +: 32];
      else model_error();
    end else begin
      model_error();
    end
  endtask

  task automatic check_all(input string tag);
    logic [32*NREGS-1:0] exp_regs;
    for (int k = 0; k < NREGS; k++) exp_regs[32*k +: 32] = m_regs[k];
    check({tag, ".rdata"}, 256'(rdata), 256'(m_rdata));
    check({tag, ".regs"}, 256'(regs), 256'(exp_regs));
    check({tag, ".wstrobe"}, 256'(wstrobe), 256'(m_wstrobe));
    check({tag, ".err"}, 256'(err_count), 256'(m_err));
  endtask

  // Drives one command for one cycle (wvalid stays high for back-to-back use).
  task automatic issue(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] data,
                       input string tag);
    wdata  = {op, 24'h5A5A5A, 8'hC3, addr, data};
    wvalid = 1'b1;
    model_apply(op, addr, data);
    @(negedge c);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    wvalid = 1'b0;
    wdata  = {$urandom, $urandom, 16'(($urandom))};
    m_wstrobe = '0;
    @(negedge c);
    check_all(tag);
  endtask

  initial begin
    r = 1'b1; wvalid = 1'b0; wdata = '0;
    stat = {32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678, 32'h11112222};
    model_reset();

    vecs[0]  = '{8'h01, 8'd3,  32'hDEADBEEF, 32'hDEADBEEF, 16'd0, 8'h08};
    vecs[1]  = '{8'h02, 8'd3,  32'h00000000, 32'hDEADBEEF, 16'd0, 8'h00};
    vecs[2]  = '{8'h01, 8'd2,  32'h0000FF00, 32'h0000FF00, 16'd0, 8'h04};
    vecs[3]  = '{8'h03, 8'd2,  32'h000000F0, 32'h0000FFF0, 16'd0, 8'h04};
    vecs[4]  = '{8'h04, 8'd2,  32'h0000F000, 32'h00000FF0, 16'd0, 8'h04};
    vecs[5]  = '{8'h02, 8'd65, 32'h00000000, 32'h12345678, 16'd0, 8'h00};
    vecs[6]  = '{8'h01, 8'd65, 32'h99999999, 32'h12345678, 16'd1, 8'h00};
    vecs[7]  = '{8'h7F, 8'd1,  32'h00000000, 32'h12345678, 16'd2, 8'h00};
    vecs[8]  = '{8'h02, 8'd20, 32'h00000000, 32'h12345678, 16'd3, 8'h00};
    vecs[9]  = '{8'h02, 8'd68, 32'h00000000, 32'h12345678, 16'd4, 8'h00};
    vecs[10] = '{8'h00, 8'd0,  32'h00000000, 32'h12345678, 16'd5, 8'h00};
    vecs[11] = '{8'h05, 8'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 16'd5, 8'h01};
    vecs[12] = '{8'h02, 8'd7,  32'h00000000, 32'h00000000, 16'd5, 8'h00};
    vecs[13] = '{8'h02, 8'd8,  32'h00000000, 32'h00000000, 16'd6, 8'h00};
    vecs[14] = '{8'h02, 8'd67, 32'h00000000, 32'hCAFEF00D, 16'd6, 8'h00};
    vecs[15] = '{8'h03, 8'd7,  32'h80000001, 32'h80000001, 16'd6, 8'h80};

    repeat (2) @(negedge c);
    r = 1'b0;
    check_all("reset");

    // Directed table, applied back-to-back.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_rdata", i), 256'(rdata), 256'(vecs[i].exp_rdata));
      check($sformatf("vec%0d.tbl_err", i), 256'(err_count), 256'(vecs[i].exp_err));
      check($sformatf("vec%0d.tbl_wstrobe", i), 256'(wstrobe), 256'(vecs[i].exp_wstrobe));
    end
    check("reg2_final", 256'(regs[95:64]), 256'(32'h00000FF0));
    check("reg3_final", 256'(regs[127:96]), 256'(32'hDEADBEEF));
    idle("idle0");

    // Unchanged-value write still strobes.
    issue(8'h01, 8'd3, 32'hDEADBEEF, "same_val");
    idle("idle1");

    // Reset together with a command: command discarded, not counted.
    wdata = {8'h01, 32'h0, 8'd4, 32'h77777777}; wvalid = 1'b1; r = 1'b1;
    @(negedge c);
    r = 1'b0; wvalid = 1'b0;
    model_reset();
    check_all("rst_cmd");

    // Random commands against the model.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] op, addr;
      int sel;
      stat[32*($urandom_range(0, NSTAT-1)) +: 32] = $urandom;
      op  = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) op = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6)       addr = 8'($urandom_range(0, NREGS-1));
      else if (sel < 8)  addr = 8'($urandom_range(64, 64 + NSTAT));
      else               addr = 8'($urandom);
      if ($urandom_range(0, 7) == 0) idle($sformatf("ridle%0d", i));
      else issue(op, addr, $urandom, $sformatf("rnd%0d", i));
    end
    idle("post_rnd");

    // Error counter saturation.
    for (int i = 0; i < 70000; i++) begin
      wdata  = {8'h00, 72'h0};
      wvalid = 1'b1;
      model_error();
      @(negedge c);
    end
    wvalid = 1'b0;
    m_wstrobe = '0;
    check("err_sat", 256'(err_count), 256'(16'hFFFF));
    check_all("sat");
    issue(8'h09, 8'd0, 32'h0, "sat_more");
    idle("sat_idle");

    // Reset clears the saturated counter.
    r = 1'b1;
    @(negedge c);
    r = 1'b0;
    model_reset();
    check_all("final_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
